systolic_skew_feeder: RTL
=========================

# systolic_skew_feeder

Parametrised input sequencer for the systolic matrix processor: accepts one column of A and one row of B per handshake beat, skews them into diagonal wavefronts, and flushes zeros until the array has drained. Generates the clear, enable and done strobes for the processing elements (PEs). It replaces the fixed-size counter control with a run-time matrix dimension, valid/ready flow control, bubble stalling and a completion pulse. It sits between the stream source and the PE grid.

## Interface

- SIZE, 4, physical array dimension (lanes per operand), ≥2
- I_BITS, 8, operand width per lane
- PE_LAT, 1, PE register latency added to the drain count, ≥1
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_dim  in  $clog2(SIZE)+1  active dimension N; sampled with beat 0; 0 or >SIZE means SIZE
- i_valid  in  1  beat valid
- o_ready  out  1  beat accept; a beat transfers when i_valid & o_ready at a rising edge
- i_a_full  in  SIZE*I_BITS  lane r bits [r*I_BITS+:I_BITS] = A[r][k]
- i_b_full  in  SIZE*I_BITS  lane c = B[k][c]
- o_a_skew  out  SIZE*I_BITS  lane r delayed by r+1 shift steps
- o_b_skew  out  SIZE*I_BITS  lane c delayed by c+1 shift steps
- o_pe_enable  out  1  PEs accumulate this cycle
- o_pe_clear  out  1  PEs clear accumulators before accumulating this cycle
- o_busy  out  1  job in progress (LOAD, FLUSH or DONE)
- o_done  out  1  one-cycle pulse: all C[i][j] with i,j<N are final

## Operation

- FSM states: IDLE, LOAD, FLUSH, DONE. Reset → IDLE.
- IDLE: o_ready=1. Accepted beat = beat 0; latch N and clear the beat counter. Go to LOAD, or go directly to FLUSH if N=1.
- LOAD: o_ready=1. Each accepted beat increments the beat counter. When beat N-1 is accepted, go to FLUSH.
- FLUSH: o_ready=0. Shift zeros every cycle for F = 2N-2+PE_LAT cycles, then go to DONE.
- DONE: o_ready=0, o_done=1 for exactly one cycle, then go to IDLE.
- shift = accepted beat | (state==FLUSH). Skew registers advance only on shift. In LOAD, i_valid=0 is a bubble: registers hold, and o_pe_enable=0 in the following cycle.
- Skew lane r is an (r+1)-deep register chain. Its input is the operand lane when a beat is accepted, and 0 in FLUSH.
- Lanes ≥N are forced to 0 at the chain input regardless of i_a_full/i_b_full.
- o_pe_enable is the registered shift, aligned with the data it validates.
- o_pe_clear is the registered (beat-0 accepted) signal. It is coincident with the first o_pe_enable of a job.
- o_ready = (IDLE|LOAD) & ~i_reset.
- No arithmetic is performed on the data path. Beat counter width is $clog2(SIZE)+1. Flush counter width is $clog2(2*SIZE+PE_LAT)+1. Counters saturate and never wrap.

## Timing

- Reset values: all skew registers 0, o_pe_enable=0, o_pe_clear=0, o_done=0, o_busy=0. o_ready=0 while i_reset=1 and 1 in the first cycle after.
- Beat k accepted at edge Ek drives lane r of o_a_skew/o_b_skew after r+1 shift edges. Lane 0 updates after Ek; with no bubbles, lane r updates after E(k+r).
- No-bubble job: beats at E0..E(N-1). FLUSH shifts occur at E(N)..E(N+F-1). o_done is high in the cycle after E(N+F-1). For N=4 and PE_LAT=1, o_done follows E10.
- Each bubble cycle delays o_done by one cycle.
- i_reset during any state aborts the job: no o_done; all registers return to reset values at that edge. A beat presented in the same cycle as i_reset is not accepted.
- The next job may start with its beat 0 in the cycle after o_done (IDLE).
- i_dim changes after beat 0 are ignored until the next job.

## Test plan

- SIZE=4, N=4, 4 back-to-back beats (A col k = {k+1,k+2,k+3,k+4}) → lane 3 shows A[3][0]=4 after E3; o_pe_clear only after E0; o_pe_enable high for 11 consecutive cycles; o_done single pulse after E10.
- N=2 on SIZE=4 with all input lanes =8'hFF → lanes 2,3 of both skews stay 0; F=3; o_done after E4.
- Bubbles: N=4, i_valid pattern 1,0,0,1,1,1 → skew outputs hold and o_pe_enable=0 during the two bubbles; o_done two cycles later than the no-bubble case (after E12).
- N=1 and i_dim=0 (→N=4): N=1 gives F=PE_LAT=1 and o_done after E1; i_dim=0 produces the N=4 timing.
- i_reset asserted in FLUSH cycle 3 → no o_done; skews all 0 after that edge; o_ready=1 in the next cycle; a fresh job completes normally.
- Back-to-back jobs: beat 0 of job 2 presented during DONE is not accepted; it is accepted in the following cycle, and o_pe_clear pulses again.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Input sequencer for the systolic array: skews A columns / B rows into diagonal wavefronts,
// flushes zeros until the grid drains, and generates PE clear/enable/done strobes.
module systolic_skew_feeder #(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned I_BITS = 8,
  parameter int unsigned PE_LAT = 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [$clog2(SIZE):0]    i_dim,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [SIZE*I_BITS-1:0]   i_a_full,
  input  logic [SIZE*I_BITS-1:0]   i_b_full,
  output logic [SIZE*I_BITS-1:0]   o_a_skew,
  output logic [SIZE*I_BITS-1:0]   o_b_skew,
  output logic                     o_pe_enable,
  output logic                     o_pe_clear,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned DW = $clog2(SIZE) + 1;
  localparam int unsigned FW = $clog2(2 * SIZE + PE_LAT) + 1;
  localparam int unsigned W  = SIZE * I_BITS;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  state_e          state_q;
  logic [DW-1:0]   n_q;
  logic [DW-1:0]   beat_q;
  logic [FW-1:0]   flush_q;
  logic            enable_q;
  logic            clear_q;
  logic            busy_q;
  logic            done_q;

  logic [DW-1:0]   dim_eff;
  logic [DW-1:0]   n_cur;
  logic [FW-1:0]   flush_last;
  logic            accept;
  logic            beat0;
  logic            shift;
  logic [W-1:0]    a_in;
  logic [W-1:0]    b_in;

  assign o_ready = ((state_q == StIdle) || (state_q == StLoad)) && !i_reset;
  assign accept  = i_valid && o_ready;
  assign beat0   = accept && (state_q == StIdle);
  assign shift   = accept || (state_q == StFlush);

  always_comb begin
    dim_eff = i_dim;
    if ((i_dim == '0) || (i_dim > DW'(SIZE))) begin
      dim_eff = DW'(SIZE);
    end
  end

  // The dimension applies to beat 0 itself, before it has been latched.
  assign n_cur = (state_q == StIdle) ? dim_eff : n_q;

  // Index of the last flush cycle: F - 1 = 2N - 3 + PE_LAT.
  assign flush_last = FW'({n_q, 1'b0}) + FW'(PE_LAT) - FW'(3);

  // Chain inputs: accepted operand lanes below N, zeros otherwise (flush or masked lane).
  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int r = 0; r < int'(SIZE); r++) begin
      if (accept && (DW'(r) < n_cur)) begin
        a_in[r*I_BITS +: I_BITS] = i_a_full[r*I_BITS +: I_BITS];
        b_in[r*I_BITS +: I_BITS] = i_b_full[r*I_BITS +: I_BITS];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= StIdle;
      n_q      <= '0;
      beat_q   <= '0;
      flush_q  <= '0;
      enable_q <= 1'b0;
      clear_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      enable_q <= shift;
      clear_q  <= beat0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            n_q     <= dim_eff;
            beat_q  <= DW'(1);
            flush_q <= '0;
            busy_q  <= 1'b1;
            state_q <= (dim_eff == DW'(1)) ? StFlush : StLoad;
          end
        end
        StLoad: begin
          if (accept) begin
            if (beat_q == n_q - DW'(1)) begin
              state_q <= StFlush;
            end else if (beat_q != '1) begin
              beat_q <= beat_q + DW'(1);
            end
          end
        end
        StFlush: begin
          if (flush_q == flush_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (flush_q != '1) begin
            flush_q <= flush_q + FW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_pe_enable = enable_q;
  assign o_pe_clear  = clear_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

  // Lane r is an (r+1)-deep shift chain; its last stage drives the output lane.
  for (genvar r = 0; r < int'(SIZE); r++) begin : g_lane
    logic [I_BITS-1:0] a_st [0:r];
    logic [I_BITS-1:0] b_st [0:r];

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        for (int j = 0; j <= r; j++) begin
          a_st[j] <= '0;
          b_st[j] <= '0;
        end
      end else if (shift) begin
        a_st[0] <= a_in[r*I_BITS +: I_BITS];
        b_st[0] <= b_in[r*I_BITS +: I_BITS];
        for (int j = 1; j <= r; j++) begin
          a_st[j] <= a_st[j-1];
          b_st[j] <= b_st[j-1];
        end
      end
    end

    assign o_a_skew[r*I_BITS +: I_BITS] = a_st[r];
    assign o_b_skew[r*I_BITS +: I_BITS] = b_st[r];
  end

endmodule
